stage_mem: RTL

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem_if.sv | 20 ++
 rtl/stage_mem.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stage_mem_if.sv
// Memory bus between the MEM pipeline stage (master) and the data memory (slave).
interface stage_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/stage_mem.sv
// MEM pipeline stage: issues loads/stores on the bus, stalls until ack or timeout, registers writeback.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned word accesses with an align_err pulse.
module stage_mem #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        alu_result,
  input  logic               wb_src,
  input  logic [4:0]         wb_reg_addr_in,
  input  logic [31:0]        mem_addr_in,
  input  logic [31:0]        mem_data_in,
  input  logic [1:0]         memwrite_opt,
  input  logic [1:0]         memread_opt,
  output logic               stall,
  stage_mem_if.master        bus,
  output logic               wb_en,
  output logic [4:0]         wb_reg_addr,
  output logic [31:0]        wb_data,
  output logic               bus_err,
  output logic               align_err
);

  typedef enum logic [1:0] {
    OPT_NONE = 2'd0,
    OPT_WORD = 2'd1,
    OPT_BYTE = 2'd2
  } mem_opt_e;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  localparam logic WB_SRC_MEM = 1'b1;
  localparam int   CNT_W      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wb_en_q, wb_en_d;
  logic [4:0]       wb_reg_addr_q, wb_reg_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             bus_err_q, bus_err_d;

  logic        is_write, is_read, is_byte, mem_op;
  logic        align_fault, mem_go, done, timeout_hit;
  logic [1:0]  lane;
  logic [7:0]  rd_byte;
  logic [31:0] load_data;

  assign is_write = (memwrite_opt != OPT_NONE);
  assign is_read  = (memread_opt != OPT_NONE);
  assign mem_op   = is_write || is_read;
  assign is_byte  = is_write ? (memwrite_opt == OPT_BYTE) : (memread_opt == OPT_BYTE);
  assign lane     = mem_addr_in[1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign align_fault = mem_op && !is_byte && (lane != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  // A request only goes out while out of reset and not rejected for alignment.
  assign mem_go      = rst && mem_op && !align_fault;
  assign done        = mem_go && bus.mem_ack;
  assign timeout_hit = (state_q == S_WAIT) && (count_q == CNT_LAST) && !bus.mem_ack;
  assign stall       = mem_go && !bus.mem_ack && !timeout_hit;

  assign bus.mem_req   = mem_go;
  assign bus.mem_we    = mem_go && is_write;
  assign bus.mem_addr  = {mem_addr_in[31:2], 2'b00};
  assign bus.mem_wdata = is_byte ? {4{mem_data_in[7:0]}} : mem_data_in;
  assign bus.mem_be    = !mem_go ? 4'b0000 : (is_byte ? (4'b0001 << lane) : 4'b1111);

  assign rd_byte   = bus.mem_rdata[{lane, 3'b000} +: 8];
  assign load_data = is_byte ? {{24{rd_byte[7]}}, rd_byte} : bus.mem_rdata;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    state_d = state_q;
    count_d = '0;
    unique case (state_q)
      S_IDLE: if (mem_go && !bus.mem_ack) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ack || timeout_hit) state_d = S_IDLE;
        else                            count_d = count_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_en_d       = 1'b0;
    wb_reg_addr_d = wb_reg_addr_q;
    wb_data_d     = wb_data_q;
    bus_err_d     = 1'b0;
    if (!mem_op) begin
      wb_en_d       = (wb_reg_addr_in != 5'd0);
      wb_reg_addr_d = wb_reg_addr_in;
      wb_data_d     = alu_result;
    end else if (done) begin
      if (is_read) begin
        wb_en_d       = (wb_reg_addr_in != 5'd0);
        wb_reg_addr_d = wb_reg_addr_in;
        wb_data_d     = (wb_src == WB_SRC_MEM) ? load_data : alu_result;
      end
    end else if (timeout_hit) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (!rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      wb_en_q       <= 1'b0;
      wb_reg_addr_q <= 5'd0;
      wb_data_q     <= 32'd0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wb_en_q       <= wb_en_d;
      wb_reg_addr_q <= wb_reg_addr_d;
      wb_data_q     <= wb_data_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign wb_en       = wb_en_q;
  assign wb_reg_addr = wb_reg_addr_q;
  assign wb_data     = wb_data_q;
  assign bus_err     = bus_err_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q, align_err_d;

  assign align_err_d = align_fault;

  always_ff @(posedge clk) begin
    if (!rst) align_err_q <= 1'b0;
    else      align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  assign align_err = 1'b0;
`endif

endmodule
